// File: rtl/rs_encode_line_dispatch.sv
// rs_encode_line_dispatch
//
// Feeds the multi-unit RS line encoder from a single line stream. Whole RS
// blocks (NUM_LINES lines each) are steered round-robin across NUM_RS_UNITS
// encoder inputs through a one-entry registered output stage. When the stream
// ends on a block that does not complete a full round of units, all-zero
// padding blocks are generated until the round is complete. The downstream
// encoder mux relies on this, because it only works on whole rounds.
//
// Ports:
//   clk                         single clock, rising edge
//   rst                         synchronous active-high reset
//   src_dispatch_line_val       input line valid
//   src_dispatch_line           input line data
//   src_dispatch_last_block     final-block marker, used on a block's last line
//   dispatch_src_line_rdy       input ready
//   dispatch_encoder_line_vals  one-hot valid, one bit per encoder unit
//   dispatch_encoder_line       line data shared by all units
//   encoder_dispatch_line_rdys  per-unit ready
//   dispatch_pad_active         registered line is padding
module rs_encode_line_dispatch #(
    parameter int DATA_W         = -1,
    parameter int NUM_LINES      = -1,
    parameter int NUM_RS_UNITS   = -1,
    parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
    parameter int NUM_LINES_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    src_dispatch_line_val,
    input  logic [DATA_W-1:0]       src_dispatch_line,
    input  logic                    src_dispatch_last_block,
    output logic                    dispatch_src_line_rdy,
    output logic [NUM_RS_UNITS-1:0] dispatch_encoder_line_vals,
    output logic [DATA_W-1:0]       dispatch_encoder_line,
    input  logic [NUM_RS_UNITS-1:0] encoder_dispatch_line_rdys,
    output logic                    dispatch_pad_active
);

    typedef enum logic {
        ST_PASS,
        ST_PAD
    } state_t;

    state_t                    state_q, state_d;
    logic                      out_val_q, out_val_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic [NUM_RS_UNITS_W-1:0] out_unit_q, out_unit_d;
    logic                      out_pad_q, out_pad_d;
    logic [NUM_LINES_W-1:0]    line_cnt_q, line_cnt_d;
    logic [NUM_RS_UNITS_W-1:0] unit_cnt_q, unit_cnt_d;

    logic [NUM_RS_UNITS-1:0]   unit_onehot;
    logic                      out_fire;
    logic                      load_ok;
    logic                      load;
    logic                      line_last;
    logic                      unit_last;

    // Decode the registered unit into a one-hot select. Only the selected
    // unit's ready can retire the line, so the other ready bits are masked off
    // here rather than indexed, which also keeps NUM_RS_UNITS==1 clean.
    always_comb begin
        unit_onehot = '0;
        for (int i = 0; i < NUM_RS_UNITS; i++) begin
            unit_onehot[i] = (out_unit_q == NUM_RS_UNITS_W'(i));
        end
    end

    // Handshake decode. While reset is asserted every output is forced low,
    // even though the registers only clear on the next edge.
    always_comb begin
        out_fire  = out_val_q & (|(encoder_dispatch_line_rdys & unit_onehot));
        load_ok   = ~out_val_q | out_fire;
        line_last = (line_cnt_q == NUM_LINES_W'(NUM_LINES - 1));
        unit_last = (unit_cnt_q == NUM_RS_UNITS_W'(NUM_RS_UNITS - 1));

        dispatch_src_line_rdy      = (state_q == ST_PASS) & load_ok & ~rst;
        dispatch_encoder_line_vals = (out_val_q & ~rst) ? unit_onehot : '0;
        dispatch_encoder_line      = rst ? '0 : out_data_q;
        dispatch_pad_active        = out_val_q & out_pad_q & ~rst;

        // Padding lines are generated internally, so they only need a free
        // output register; real lines also need the source to offer one.
        if (state_q == ST_PASS) begin
            load = src_dispatch_line_val & dispatch_src_line_rdy;
        end else begin
            load = load_ok;
        end
    end

    // Next-state logic for the output register, the block/unit counters and
    // the PASS/PAD controller. A load and a fire in the same cycle simply
    // overwrite the register, which gives full throughput with no bubble.
    always_comb begin
        state_d    = state_q;
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_unit_d = out_unit_q;
        out_pad_d  = out_pad_q;
        line_cnt_d = line_cnt_q;
        unit_cnt_d = unit_cnt_q;

        if (load) begin
            out_val_d  = 1'b1;
            out_unit_d = unit_cnt_q;
            if (state_q == ST_PAD) begin
                out_data_d = '0;
                out_pad_d  = 1'b1;
            end else begin
                out_data_d = src_dispatch_line;
                out_pad_d  = 1'b0;
            end

            if (line_last) begin
                line_cnt_d = '0;
                if (unit_last) begin
                    unit_cnt_d = '0;
                end else begin
                    unit_cnt_d = unit_cnt_q + NUM_RS_UNITS_W'(1);
                end
            end else begin
                line_cnt_d = line_cnt_q + NUM_LINES_W'(1);
            end

            // The final-block marker matters only on a block's last line, and
            // only when that block leaves units of the round unfilled.
            if (state_q == ST_PASS) begin
                if (line_last && src_dispatch_last_block && !unit_last) begin
                    state_d = ST_PAD;
                end
            end else begin
                if (line_last && unit_last) begin
                    state_d = ST_PASS;
                end
            end
        end else if (out_fire) begin
            out_val_d = 1'b0;
        end
    end

    // State register. Reset drops any held line along with all partial block
    // and padding progress, so the next line starts at unit 0, line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PASS;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_unit_q <= '0;
            out_pad_q  <= 1'b0;
            line_cnt_q <= '0;
            unit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_unit_q <= out_unit_d;
            out_pad_q  <= out_pad_d;
            line_cnt_q <= line_cnt_d;
            unit_cnt_q <= unit_cnt_d;
        end
    end

endmodule

// File: tb/tb_rs_encode_line_dispatch.sv
// Testbench for rs_encode_line_dispatch with DATA_W=64, NUM_LINES=4,
// NUM_RS_UNITS=3. The reference model tracks the presented line, the position
// within the current round of NUM_LINES*NUM_RS_UNITS lines, and how many
// padding lines are still owed.
module tb_rs_encode_line_dispatch;

    localparam int DW = 64;
    localparam int NL = 4;
    localparam int NU = 3;
    localparam int ROUND = NL * NU;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_val;
    logic [DW-1:0] src_line;
    logic          src_last;
    logic          src_rdy;
    logic [NU-1:0] enc_vals;
    logic [DW-1:0] enc_line;
    logic [NU-1:0] enc_rdys;
    logic          pad_active;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit            m_val = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_unit = 0;
    bit            m_pad = 1'b0;
    int            m_pos = 0;
    int            m_pad_left = 0;

    int pad_cycles;
    int unit0_cycles;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    rs_encode_line_dispatch #(
        .DATA_W(DW),
        .NUM_LINES(NL),
        .NUM_RS_UNITS(NU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_dispatch_line_val(src_val),
        .src_dispatch_line(src_line),
        .src_dispatch_last_block(src_last),
        .dispatch_src_line_rdy(src_rdy),
        .dispatch_encoder_line_vals(enc_vals),
        .dispatch_encoder_line(enc_line),
        .encoder_dispatch_line_rdys(enc_rdys),
        .dispatch_pad_active(pad_active)
    );

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic compareValue(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic checkOutput();
        logic [NU-1:0] exp_vals;
        logic          exp_rdy;
        logic          exp_pad;
        exp_vals = (rst || !m_val) ? '0 : NU'(1 << m_unit);
        exp_rdy  = !rst && (m_pad_left == 0) && (!m_val || enc_rdys[m_unit]);
        exp_pad  = !rst && m_val && m_pad;
        compareValue("src_rdy", DW'(src_rdy), DW'(exp_rdy));
        compareValue("vals", DW'(enc_vals), DW'(exp_vals));
        compareValue("pad_active", DW'(pad_active), DW'(exp_pad));
        if (!rst && m_val) begin
            compareValue("data", enc_line, m_data);
        end
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model to
    // what the coming rising edge should produce
    task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d,
                                 input logic lb, input logic [NU-1:0] rd);
        bit fire;
        bit free;
        @(negedge clk);
        rst      = r;
        src_val  = v;
        src_line = d;
        src_last = lb;
        enc_rdys = rd;
        #1;
        checkOutput();
        if (r) begin
            m_val      = 1'b0;
            m_pad      = 1'b0;
            m_pos      = 0;
            m_pad_left = 0;
        end else begin
            fire = m_val && rd[m_unit];
            free = !m_val || fire;
            if (m_pad_left > 0) begin
                if (free) begin
                    m_val  = 1'b1;
                    m_data = '0;
                    m_pad  = 1'b1;
                    m_unit = m_pos / NL;
                    m_pos  = (m_pos + 1) % ROUND;
                    m_pad_left--;
                end
            end else if (v && free) begin
                m_val  = 1'b1;
                m_data = d;
                m_pad  = 1'b0;
                m_unit = m_pos / NL;
                if (lb && (m_pos % NL == NL - 1)) begin
                    m_pad_left = ROUND - 1 - m_pos;
                end
                m_pos = (m_pos + 1) % ROUND;
            end else if (fire) begin
                m_val = 1'b0;
            end
        end
    endtask

    function automatic logic [DW-1:0] rndLine();
        return {$urandom, $urandom};
    endfunction

    // Feed lines until the model sits at the start of a round with no padding owed
    task automatic alignRound();
        for (int i = 0; i < 3 * ROUND; i++) begin
            if (m_pos == 0 && m_pad_left == 0) break;
            applyStimulus(1'b0, 1'b1, rndLine(), 1'b0, '1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        src_val  = 1'b0;
        src_line = '0;
        src_last = 1'b0;
        enc_rdys = '1;

        // Reset with input valid held high, then first line to unit 0
        $display("[TB] reset with valid high");
        applyStimulus(1'b1, 1'b1, rndLine(), 1'b0, '1);
        applyStimulus(1'b1, 1'b1, rndLine(), 1'b0, '1);

        // Back-to-back full round, all units ready
        $display("[TB] back-to-back round");
        for (int i = 0; i < ROUND; i++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), 1'b0, '1);
        end

        // Unit 1 stalls for 5 cycles while its block is presented
        $display("[TB] unit 1 backpressure");
        alignRound();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), 1'b0,
                          (c >= 6 && c < 11) ? 3'b101 : 3'b111);
        end

        // Stream ends on unit 0: two padding blocks follow
        $display("[TB] padding after unit 0 final block");
        alignRound();
        pad_cycles = 0;
        for (int i = 0; i < NL; i++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), (i == NL - 1), '1);
            if (pad_active) pad_cycles++;
        end
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), 1'b0, '1);
            if (pad_active) pad_cycles++;
        end
        compareValue("pad_count_unit0", DW'(pad_cycles), DW'(2 * NL));

        // Stream ends on unit 2: no padding at all
        $display("[TB] final block on last unit");
        alignRound();
        pad_cycles = 0;
        for (int i = 0; i < ROUND + NL; i++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), (i == ROUND - 1), '1);
            if (pad_active) pad_cycles++;
        end
        compareValue("pad_count_unit2", DW'(pad_cycles), DW'(0));

        // Reset mid-block with a held line
        $display("[TB] reset mid-block");
        alignRound();
        for (int i = 0; i < NL + 2; i++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), 1'b0, '1);
        end
        applyStimulus(1'b0, 1'b1, rndLine(), 1'b0, '0);
        applyStimulus(1'b1, 1'b1, rndLine(), 1'b0, '0);
        unit0_cycles = 0;
        for (int i = 0; i < NL + 1; i++) begin
            applyStimulus(1'b0, 1'b1, rndLine(), 1'b0, '1);
            if (enc_vals == 3'b001) unit0_cycles++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '1);
        if (enc_vals == 3'b001) unit0_cycles++;
        compareValue("post_reset_unit0_lines", DW'(unit0_cycles), DW'(NL));

        // Randomized traffic, backpressure, end-of-stream markers and resets
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                          rndLine(), ($urandom_range(0, 5) == 0), NU'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
